// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE -> PLAY -> DYING -> OVER -> IDLE.
// Edge-detects the button, gates bird/column motion via run, times the
// death animation with a down-counter and tracks the best score since reset.
module game_sequencer #(
  parameter int unsigned DEATH_CYCLES = 60,
  parameter logic [10:0] FLOOR_Y      = 11'd0
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        btn,
  input  logic        hitColumn,
  input  logic [10:0] bird_y,
  input  logic [9:0]  score,
  output logic        run,
  output logic        flap,
  output logic        restart,
  output logic [1:0]  state,
  output logic [9:0]  high_score,
  output logic        new_best,
  output logic        blink
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  // Counter starts one below the dwell so the exit at zero gives exactly
  // DEATH_CYCLES cycles in DYING.
  localparam logic [7:0] CNT_LOAD = 8'(DEATH_CYCLES - 1);

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic        flap_q, flap_d;
  logic        restart_q, restart_d;
  logic        blink_q, blink_d;
  logic        new_best_q, new_best_d;
  logic [9:0]  high_q, high_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        btn_q;
  logic        press;
  logic        dead;

  assign press = btn & ~btn_q;
  assign dead  = hitColumn | (bird_y <= FLOOR_Y);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    flap_d     = 1'b0;
    restart_d  = 1'b0;
    blink_d    = blink_q;
    new_best_d = new_best_q;
    high_d     = high_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        run_d = 1'b0;
        if (press) begin
          state_d = PLAY;
          run_d   = 1'b1;
          flap_d  = 1'b1;
        end
      end
      PLAY: begin
        // Death wins over a flap on the same edge.
        if (dead) begin
          state_d = DYING;
          run_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          blink_d = CNT_LOAD[3];
        end else begin
          flap_d = press;
        end
      end
      DYING: begin
        if (cnt_q == 8'd0) begin
          state_d = OVER;
          blink_d = 1'b0;
          if (score > high_q) begin
            high_d     = score;
            new_best_d = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - 8'd1;
          blink_d = cnt_d[3];
        end
      end
      OVER: begin
        run_d = 1'b0;
        if (press) begin
          state_d    = IDLE;
          restart_d  = 1'b1;
          new_best_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      flap_q     <= 1'b0;
      restart_q  <= 1'b0;
      blink_q    <= 1'b0;
      new_best_q <= 1'b0;
      high_q     <= 10'd0;
      cnt_q      <= 8'd0;
      btn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      flap_q     <= flap_d;
      restart_q  <= restart_d;
      blink_q    <= blink_d;
      new_best_q <= new_best_d;
      high_q     <= high_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn;
    end
  end

  assign state      = state_q;
  assign run        = run_q;
  assign flap       = flap_q;
  assign restart    = restart_q;
  assign blink      = blink_q;
  assign new_best   = new_best_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  localparam int DC = 60;

  logic        gameClk = 1'b0;
  logic        reset = 1'b0;
  logic        btn = 1'b0;
  logic        hitColumn = 1'b0;
  logic [10:0] bird_y = 11'd100;
  logic [9:0]  score = 10'd0;
  logic        run, flap, restart, blink, new_best;
  logic [1:0]  state;
  logic [9:0]  high_score;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 gameClk = ~gameClk;

  game_sequencer dut (
    .gameClk    (gameClk),
    .reset      (reset),
    .btn        (btn),
    .hitColumn  (hitColumn),
    .bird_y     (bird_y),
    .score      (score),
    .run        (run),
    .flap       (flap),
    .restart    (restart),
    .state      (state),
    .high_score (high_score),
    .new_best   (new_best),
    .blink      (blink)
  );

  // {state, run, flap, restart, blink, new_best, high_score}
  function automatic logic [16:0] pk(input logic [1:0] st, input logic r, input logic f,
                                     input logic rs, input logic bl, input logic nb,
                                     input logic [9:0] hs);
    return {st, r, f, rs, bl, nb, hs};
  endfunction

  task automatic expect_out(input string tag, input logic [16:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    logic [16:0] obs;
    obs = {state, run, flap, restart, blink, new_best, high_score};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b, no expected entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed st=%0d run=%b flap=%b rst=%b blink=%b nb=%b hs=%0d, expected st=%0d run=%b flap=%b rst=%b blink=%b nb=%b hs=%0d",
               x.tag, obs[16:15], obs[14], obs[13], obs[12], obs[11], obs[10], obs[9:0],
               x.exp[16:15], x.exp[14], x.exp[13], x.exp[12], x.exp[11], x.exp[10], x.exp[9:0]);
      end
    end
  endtask

  task automatic step();
    @(posedge gameClk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [16:0] e);
    expect_out(tag, e);
    step();
    check_out();
  endtask

  // Runs the remaining DC-1 DYING cycles after entry (presses and hits
  // ignored), then the transition into OVER.
  task automatic dying_run(input logic [9:0] hs_before, input logic [9:0] hs_after,
                           input logic nb_after);
    logic [7:0] cnt;
    for (int i = 1; i < DC; i++) begin
      btn       = i[0];
      hitColumn = i[1];
      cnt       = 8'(DC - 1 - i);
      cyc("dying", pk(2'd2, 1'b0, 1'b0, 1'b0, cnt[3], 1'b0, hs_before));
    end
    btn       = 1'b0;
    hitColumn = 1'b0;
    cyc("over_entry", pk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, nb_after, hs_after));
  endtask

  // OVER -> IDLE (restart pulse) -> PLAY.
  task automatic new_round(input logic [9:0] hs);
    btn = 1'b1;
    cyc("over_press_restart", pk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hs));
    cyc("restart_one_cycle", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hs));
    btn = 1'b0;
    cyc("idle_wait", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hs));
    btn = 1'b1;
    cyc("second_press_play", pk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, hs));
    btn = 1'b0;
    cyc("play_no_flap", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hs));
  endtask

  initial begin
    // Reset held: async values visible before any edge and across an edge.
    #2;
    expect_out("reset_async", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    check_out();
    btn = 1'b1;
    cyc("reset_hold_edge", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    btn = 1'b0;
    step();
    reset = 1'b1;

    cyc("idle_no_press", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    hitColumn = 1'b1; bird_y = 11'd0;
    cyc("idle_ignore_hit", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    hitColumn = 1'b0; bird_y = 11'd100;

    // Start, then hold the button: exactly one flap.
    btn = 1'b1;
    cyc("start_press", pk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0));
    for (int i = 0; i < 9; i++)
      cyc("held_no_flap", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    btn = 1'b0;
    cyc("release", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));

    // Three presses four cycles apart.
    for (int p = 0; p < 3; p++) begin
      btn = 1'b1;
      cyc("flap_pulse", pk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0));
      btn = 1'b0;
      for (int k = 0; k < 3; k++)
        cyc("flap_gap", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    end

    // Just above the floor is still alive.
    bird_y = 11'd1;
    cyc("above_floor", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    bird_y = 11'd100;

    // Hit and press together: death wins. 59 = 0b0011_1011, bit3 = 1.
    btn = 1'b1; hitColumn = 1'b1;
    cyc("die_hit_press", pk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0));
    dying_run(10'd0, 10'd0, 1'b0);

    hitColumn = 1'b1; bird_y = 11'd0;
    cyc("over_ignore_hit", pk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    hitColumn = 1'b0; bird_y = 11'd100;

    // Round 2: floor death with score 7 -> new best.
    new_round(10'd0);
    score = 10'd7; bird_y = 11'd0;
    cyc("die_floor", pk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0));
    bird_y = 11'd100;
    dying_run(10'd0, 10'd7, 1'b1);

    // Round 3: equal score -> no new best, high score retained.
    new_round(10'd7);
    bird_y = 11'd0;
    cyc("die_equal", pk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd7));
    bird_y = 11'd100;
    dying_run(10'd7, 10'd7, 1'b0);

    // Round 4: lower score.
    new_round(10'd7);
    score = 10'd3; bird_y = 11'd0;
    cyc("die_lower", pk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd7));
    bird_y = 11'd100;
    dying_run(10'd7, 10'd7, 1'b0);

    // Round 5: higher score 9, reset 20 cycles into DYING.
    new_round(10'd7);
    score = 10'd9; hitColumn = 1'b1;
    cyc("die_round5", pk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd7));
    hitColumn = 1'b0;
    for (int i = 1; i < 20; i++) begin
      logic [7:0] cnt;
      cnt = 8'(DC - 1 - i);
      cyc("dying_pre_reset", pk(2'd2, 1'b0, 1'b0, 1'b0, cnt[3], 1'b0, 10'd7));
    end
    reset = 1'b0;
    #1;
    expect_out("reset_mid_dying", pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    check_out();

    // Button already high when reset releases counts as a press.
    btn = 1'b1;
    step();
    reset = 1'b1;
    cyc("press_at_reset_release", pk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0));
    cyc("held_after_release", pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
    btn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter DEATH_CYCLES, default 60, giving the number of gameClk cycles spent in DYING; legal range is 1..255.
REQ-002 The block SHALL have parameter FLOOR_Y, default 11'd0, giving the bird height at or below which the bird has hit the ground.
REQ-003 The block SHALL have port gameClk, input, 1 bit: the single game tick clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: an asynchronous, active-low reset.
REQ-005 The block SHALL have port btn, input, 1 bit: the flap/start button level, already synchronous to gameClk.
REQ-006 The block SHALL have port hitColumn, input, 1 bit: the column collision flag from collision detection.
REQ-007 The block SHALL have port bird_y, input, 11 bits: the bird height, unsigned, with 0 at the ground.
REQ-008 The block SHALL have port score, input, 10 bits: the current round score, unsigned.
REQ-009 The block SHALL have port run, output, 1 bit: the advance enable for bird and column logic; the top derives finished = ~run.
REQ-010 The block SHALL have port flap, output, 1 bit: a one-cycle flap pulse to bird movement.
REQ-011 The block SHALL have port restart, output, 1 bit: a one-cycle soft clear pulse to the bird, column and score logic.
REQ-012 The block SHALL have port state, output, 2 bits: IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-013 The block SHALL have port high_score, output, 10 bits: the best score since reset.
REQ-014 The block SHALL have port new_best, output, 1 bit: set when the last round beat high_score.
REQ-015 The block SHALL have port blink, output, 1 bit: the display flash enable during DYING.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 A press SHALL be defined as btn=1 while btn_q=0, where btn_q is btn registered on the previous edge; a held button SHALL yield exactly one press.
REQ-018 In IDLE, run SHALL be 0; on a press the next state SHALL be PLAY, with run<=1 and flap<=1 for one cycle.
REQ-019 In PLAY, each press SHALL produce flap=1 for exactly the following cycle.
REQ-020 In PLAY, if hitColumn=1 or bird_y<=FLOOR_Y, the next state SHALL be DYING, with run<=0, the counter loaded with DEATH_CYCLES-1, and flap held at 0.
REQ-021 In PLAY, death SHALL take priority over a simultaneous press.
REQ-022 In DYING, the counter SHALL decrement each cycle and blink SHALL equal counter bit 3.
REQ-023 In DYING, presses and hitColumn SHALL be ignored.
REQ-024 In DYING, when counter=0, the next state SHALL be OVER with blink<=0.
REQ-025 On the DYING-to-OVER transition, if score>high_score (unsigned compare), the block SHALL set high_score<=score and new_best<=1; on equal or lower scores neither SHALL change.
REQ-026 In OVER, run SHALL be 0; on a press the next state SHALL be IDLE, with restart<=1 for one cycle and new_best<=0.
REQ-027 hitColumn and bird_y SHALL be ignored in IDLE and OVER.
REQ-028 restart and flap SHALL never be 1 in the same cycle.
REQ-029 restart SHALL never be asserted while run=1.
REQ-030 high_score SHALL survive restart and be cleared only by reset.
REQ-031 The counter SHALL be 8 bits wide and SHALL NOT wrap, since the DYING exit occurs at 0.

Reset
REQ-032 While reset=0, the block SHALL hold state=IDLE, run=0, flap=0, restart=0, blink=0, new_best=0, high_score=0, counter=0 and btn_q=0, asynchronously.
REQ-033 Reset deassertion SHALL take effect at the next gameClk edge.
REQ-034 Reset asserted mid-DYING SHALL abort directly to IDLE with no high_score update.
REQ-035 If btn=1 when reset deasserts, it SHALL count as a press on the first edge, since btn_q=0.

Verification
REQ-036 Scenario: reset, btn 0->1 held 10 cycles -> state 0->1 one cycle after the press, flap high for exactly 1 cycle, run=1, no further flaps.
REQ-037 Scenario: in PLAY, 3 presses spaced 4 cycles apart -> exactly 3 single-cycle flap pulses, each 1 cycle after its press.
REQ-038 Scenario: in PLAY, hitColumn=1 and a press on the same edge -> state=2, run=0, flap=0; OVER is reached after exactly 60 cycles, and blink toggles every 8 cycles meanwhile.
REQ-039 Scenario: in PLAY, bird_y=0 with score=7 and high_score=0 -> DYING then OVER; high_score=7, new_best=1. A second round dying with score=7 -> high_score=7, new_best=0.
REQ-040 Scenario: in OVER, a press -> state=0, restart=1 for exactly 1 cycle, new_best=0, high_score retained; a second press -> state=1.
REQ-041 Scenario: reset pulled low 20 cycles into DYING -> all outputs immediately at reset values, high_score=0.
